cmac_host_master: RTL

- Hardware initiator for the FPGA-side CMAC command/data wrapper protocol. It takes the ARM's role so CMAC tags can be computed on-chip, for self-test and streaming use, without software.
- Accepts a key plus a stream of 128-bit message blocks from a local client.
- Issues the command sequence READ_KEY, INIT, then READ_BLOCK/NEXT for each block, then WRITE, and returns the 128-bit tag.

---
 rtl/cmac_host_master.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/cmac_host_master.sv
// cmac_host_master
//   Hardware initiator for the CMAC command/data wrapper. Replays the host's
//   command sequence so a tag can be produced on-chip:
//     READ_KEY, INIT, { READ_BLOCK, NEXT } per block, WRITE
//   and returns the 128-bit tag from the WRITE result.
//
//   Every command is one transaction through CMD -> [DATA | RESULT] ->
//   WAIT_DONE -> ACK -> WAIT_DONE_LOW. The wrapper's done flag is registered
//   and can linger after the acknowledge, so a new command is only issued once
//   done has been observed low.
//
//   Optional build macro CMAC_MASTER_TIMEOUT_EN: bounds every wrapper wait by
//   TIMEOUT_CYCLES; on expiry the sequence is abandoned with error=1. Without
//   the macro, waits are unbounded and error is tied low.
//
// Ports
//   clk, resetn                 clock, async active-low reset
//   start, key, keylen          launch a tag computation (sampled on start)
//   blk_valid/ready/data/last/final_size   client message block stream
//   tag, tag_valid              result and its one-cycle update strobe
//   busy, error                 status (error sticky until next accepted start)
//   arm_to_fpga_cmd[_valid]     command word and strobe
//   fpga_to_arm_done[_read]     wrapper done level and acknowledge pulse
//   arm_to_fpga_data*           outbound data handshake
//   fpga_to_arm_data*           inbound result handshake (tag in [127:0])

module cmac_host_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [255:0]  key,
  input  logic          keylen,
  input  logic          blk_valid,
  output logic          blk_ready,
  input  logic [127:0]  blk_data,
  input  logic          blk_last,
  input  logic [7:0]    blk_final_size,
  output logic [127:0]  tag,
  output logic          tag_valid,
  output logic          busy,
  output logic          error,
  output logic [31:0]   arm_to_fpga_cmd,
  output logic          arm_to_fpga_cmd_valid,
  input  logic          fpga_to_arm_done,
  output logic          fpga_to_arm_done_read,
  output logic          arm_to_fpga_data_valid,
  input  logic          arm_to_fpga_data_ready,
  output logic [1023:0] arm_to_fpga_data,
  input  logic          fpga_to_arm_data_valid,
  output logic          fpga_to_arm_data_ready,
  input  logic [1023:0] fpga_to_arm_data
);

  localparam logic [31:0] CMD_READ_KEY   = 32'd0;
  localparam logic [31:0] CMD_READ_BLOCK = 32'd1;
  localparam logic [31:0] CMD_INIT       = 32'd2;
  localparam logic [31:0] CMD_NEXT       = 32'd3;
  localparam logic [31:0] CMD_WRITE      = 32'd4;

  typedef enum logic [2:0] {
    PH_IDLE, PH_KEY, PH_INIT, PH_LOADBLK, PH_NEXT, PH_WRITE
  } phase_t;

  typedef enum logic [2:0] {
    TS_IDLE, TS_CMD, TS_DATA, TS_RESULT, TS_WAIT_DONE, TS_ACK, TS_WAIT_DONE_LOW
  } tstate_t;

  phase_t       phase;
  tstate_t      tstate;
  logic         last_q;
  logic [127:0] tag_hold;
  logic         tmo;
  logic         start_ok;

  // A start coinciding with the tag_valid cycle is dropped so the client
  // always gets to see the finished tag before a new run is accepted.
  assign start_ok = start && !busy && !tag_valid;

`ifdef CMAC_MASTER_TIMEOUT_EN
  tstate_t     tstate_d;
  logic [31:0] tcnt;
  logic        in_wait;
  logic        unused_bits;

  // tcnt = cycles spent in the current state minus one, valid once the
  // delayed copy of the state has caught up (tstate == tstate_d).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tstate_d <= TS_IDLE;
      tcnt     <= '0;
    end else begin
      tstate_d <= tstate;
      tcnt     <= (tstate != tstate_d) ? 32'd1 : tcnt + 32'd1;
    end
  end

  assign in_wait = (tstate == TS_DATA) || (tstate == TS_RESULT) ||
                   (tstate == TS_WAIT_DONE) || (tstate == TS_WAIT_DONE_LOW);
  assign tmo = in_wait && (tstate == tstate_d) && (tcnt >= TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       error <= 1'b0;
    else if (start_ok) error <= 1'b0;
    else if (tmo)      error <= 1'b1;
  end

  assign unused_bits = ^fpga_to_arm_data[1023:128];
`else
  logic unused_bits;

  assign tmo         = 1'b0;
  assign error       = 1'b0;
  assign unused_bits = ^{fpga_to_arm_data[1023:128], TIMEOUT_CYCLES};
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase                  <= PH_IDLE;
      tstate                 <= TS_IDLE;
      last_q                 <= 1'b0;
      tag_hold               <= '0;
      tag                    <= '0;
      tag_valid              <= 1'b0;
      busy                   <= 1'b0;
      blk_ready              <= 1'b0;
      arm_to_fpga_cmd        <= '0;
      arm_to_fpga_cmd_valid  <= 1'b0;
      fpga_to_arm_done_read  <= 1'b0;
      arm_to_fpga_data_valid <= 1'b0;
      arm_to_fpga_data       <= '0;
      fpga_to_arm_data_ready <= 1'b0;
    end else begin
      // single-cycle strobes
      tag_valid             <= 1'b0;
      arm_to_fpga_cmd_valid <= 1'b0;
      fpga_to_arm_done_read <= 1'b0;

      if (tmo) begin
        phase                  <= PH_IDLE;
        tstate                 <= TS_IDLE;
        busy                   <= 1'b0;
        blk_ready              <= 1'b0;
        arm_to_fpga_data_valid <= 1'b0;
        fpga_to_arm_data_ready <= 1'b0;
      end else begin
        case (tstate)
          TS_IDLE: begin
            if (phase == PH_IDLE) begin
              if (start_ok) begin
                busy                  <= 1'b1;
                phase                 <= PH_KEY;
                arm_to_fpga_data      <= {767'd0, keylen, key};
                arm_to_fpga_cmd       <= CMD_READ_KEY;
                arm_to_fpga_cmd_valid <= 1'b1;
                tstate                <= TS_CMD;
              end
            end else if (phase == PH_LOADBLK) begin
              // blk_ready is a registered one-cycle offer; if the client
              // withdrew valid meanwhile, simply offer again.
              if (blk_ready) begin
                blk_ready <= 1'b0;
                if (blk_valid) begin
                  last_q                <= blk_last;
                  arm_to_fpga_data      <= {887'd0, blk_last, blk_final_size, blk_data};
                  arm_to_fpga_cmd       <= CMD_READ_BLOCK;
                  arm_to_fpga_cmd_valid <= 1'b1;
                  tstate                <= TS_CMD;
                end
              end else if (blk_valid) begin
                blk_ready <= 1'b1;
              end
            end
          end

          TS_CMD: begin
            if (phase == PH_KEY || phase == PH_LOADBLK) begin
              arm_to_fpga_data_valid <= 1'b1;
              tstate                 <= TS_DATA;
            end else if (phase == PH_WRITE) begin
              fpga_to_arm_data_ready <= 1'b1;
              tstate                 <= TS_RESULT;
            end else begin
              tstate <= TS_WAIT_DONE;
            end
          end

          TS_DATA: begin
            if (arm_to_fpga_data_ready) begin
              arm_to_fpga_data_valid <= 1'b0;
              tstate                 <= TS_WAIT_DONE;
            end
          end

          TS_RESULT: begin
            if (fpga_to_arm_data_valid) begin
              tag_hold               <= fpga_to_arm_data[127:0];
              fpga_to_arm_data_ready <= 1'b0;
              tstate                 <= TS_WAIT_DONE;
            end
          end

          TS_WAIT_DONE: begin
            if (fpga_to_arm_done) begin
              fpga_to_arm_done_read <= 1'b1;
              tstate                <= TS_ACK;
            end
          end

          TS_ACK: tstate <= TS_WAIT_DONE_LOW;

          TS_WAIT_DONE_LOW: begin
            if (!fpga_to_arm_done) begin
              case (phase)
                PH_KEY: begin
                  phase                 <= PH_INIT;
                  arm_to_fpga_cmd       <= CMD_INIT;
                  arm_to_fpga_cmd_valid <= 1'b1;
                  tstate                <= TS_CMD;
                end
                PH_INIT: begin
                  phase  <= PH_LOADBLK;
                  tstate <= TS_IDLE;
                end
                PH_LOADBLK: begin
                  phase                 <= PH_NEXT;
                  arm_to_fpga_cmd       <= CMD_NEXT;
                  arm_to_fpga_cmd_valid <= 1'b1;
                  tstate                <= TS_CMD;
                end
                PH_NEXT: begin
                  if (last_q) begin
                    phase                 <= PH_WRITE;
                    arm_to_fpga_cmd       <= CMD_WRITE;
                    arm_to_fpga_cmd_valid <= 1'b1;
                    tstate                <= TS_CMD;
                  end else begin
                    phase  <= PH_LOADBLK;
                    tstate <= TS_IDLE;
                  end
                end
                PH_WRITE: begin
                  tag       <= tag_hold;
                  tag_valid <= 1'b1;
                  busy      <= 1'b0;
                  phase     <= PH_IDLE;
                  tstate    <= TS_IDLE;
                end
                default: begin
                  phase  <= PH_IDLE;
                  tstate <= TS_IDLE;
                end
              endcase
            end
          end

          default: tstate <= TS_IDLE;
        endcase
      end
    end
  end

endmodule
